// File: rtl/mem_access_unit.sv
// mem_access_unit: latches a load/store command and runs it over a req/ack memory
// handshake, reporting misalignment and time-outs back to the control unit.
module mem_access_unit #(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              start,
    input  logic              rw,
    input  logic [1:0]        size,
    input  logic              sign,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              mem_req,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);
    typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE, FAULT} state_t;
    state_t            state;
    logic [ADDR_W-1:0] mar;
    logic [31:0]       wdata_q, mdr, load_val;
    logic [3:0]        be_q;
    logic [1:0]        lane, size_q;
    logic              rw_q, sign_q, misaligned;
    logic [7:0]        cnt, byte_sel;
    logic [15:0]       half_sel;
    always_comb begin
        misaligned = size == 2'b11 || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        byte_sel   = mem_rdata[{lane, 3'b000} +: 8];
        half_sel   = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_val   = size_q == 2'b00 ? {{24{sign_q & byte_sel[7]}}, byte_sel} :
                     size_q == 2'b01 ? {{16{sign_q & half_sel[15]}}, half_sel} : mem_rdata;
    end
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state   <= IDLE;
            mar     <= '0;
            wdata_q <= '0;
            mdr     <= '0;
            be_q    <= '0;
            lane    <= '0;
            size_q  <= '0;
            rw_q    <= 1'b0;
            sign_q  <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mar     <= addr[ADDR_W-1:0];
                    lane    <= addr[1:0];
                    rw_q    <= rw;
                    size_q  <= size;
                    sign_q  <= sign;
                    be_q    <= size == 2'b00 ? 4'b0001 << addr[1:0] :
                               size == 2'b01 ? 4'b0011 << addr[1:0] : 4'b1111;
                    wdata_q <= size == 2'b00 ? {4{wdata[7:0]}} :
                               size == 2'b01 ? {2{wdata[15:0]}} : wdata;
                    cnt     <= '0;
                    state   <= misaligned ? FAULT : ACCESS;
                end
                ACCESS: if (mem_ack) begin
                    if (rw_q) mdr <= load_val;
                    state <= COMPLETE;
                end else begin
                    cnt <= cnt + 8'd1;
                    if (cnt + 8'd1 == 8'(TIMEOUT_CYC)) state <= FAULT;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign rdata     = mdr;
    assign busy      = state != IDLE;
    assign done      = state == COMPLETE || state == FAULT;
    assign err       = state == FAULT;
    assign mem_req   = state == ACCESS;
    assign mem_we    = mem_req & ~rw_q;
    assign mem_be    = mem_req ? be_q : 4'b0000;
    assign mem_addr  = mar;
    assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table vectors, hand-written corner sequences and random
// commands checked against an arithmetic model of the access unit.
module tb_mem_access_unit;
    logic        CLK = 1'b0, CLR = 1'b0;
    logic        start = 1'b0, rw = 1'b0, sign = 1'b0, mem_ack = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
    logic [31:0] rdata, mem_wdata;
    logic        busy, done, err, mem_req, mem_we;
    logic [7:0]  mem_addr;
    logic [3:0]  mem_be;
    int          n_vec = 0, n_bad = 0;
    logic [31:0] mdr_model = '0;

    mem_access_unit #(.ADDR_W(8), .TIMEOUT_CYC(15)) dut (
        .CLK(CLK), .CLR(CLR), .start(start), .rw(rw), .size(size), .sign(sign),
        .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_req(mem_req),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic rw; logic [1:0] size; logic sign;
        logic [31:0] addr, wdata, rmem;
        int ack, e_req, e_done; logic e_err;
        logic [3:0] e_be; logic [31:0] e_wd, e_rd;
    } vec_t;
    vec_t tbl[9];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issues one command and watches it until done; ack is driven in cycle ack_at.
    task automatic do_op(input logic rw_i, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] w, input logic [31:0] rm,
                         input int ack_at, output int req_n, output int done_c,
                         output logic err_o, output logic [3:0] be_o, output logic [31:0] wd_o,
                         output logic we_o, output logic [7:0] addr_o, output logic [31:0] rd_o);
        req_n = 0; done_c = -1; err_o = 0; be_o = 0; wd_o = 0; we_o = 0; addr_o = 0; rd_o = 0;
        rw = rw_i; size = sz; sign = sg; addr = a; wdata = w; start = 1'b1;
        tick();
        start = 1'b0; rw = 1'($urandom); size = 2'($urandom); sign = 1'($urandom);
        addr = $urandom; wdata = $urandom;
        for (int c = 1; c <= 40; c++) begin
            if (mem_req) begin
                if (req_n == 0) begin be_o = mem_be; wd_o = mem_wdata; we_o = mem_we; addr_o = mem_addr; end
                req_n++;
            end
            if (done) begin done_c = c; err_o = err; rd_o = rdata; break; end
            mem_ack = (c == ack_at);
            mem_rdata = (c == ack_at) ? rm : $urandom;
            tick();
        end
        mem_ack = 1'b0;
        tick();
    endtask

    task automatic run_check(input string tag, input logic rw_i, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] w, input logic [31:0] rm,
                             input int ack_at, input int e_req, input int e_done, input logic e_err,
                             input logic [3:0] e_be, input logic [31:0] e_wd, input logic [31:0] e_rd);
        int req_n, done_c;
        logic err_o, we_o;
        logic [3:0] be_o;
        logic [31:0] wd_o, rd_o;
        logic [7:0] addr_o;
        do_op(rw_i, sz, sg, a, w, rm, ack_at, req_n, done_c, err_o, be_o, wd_o, we_o, addr_o, rd_o);
        chk({tag, " done_cycle"}, done_c, e_done);
        chk({tag, " err"}, {31'd0, err_o}, {31'd0, e_err});
        chk({tag, " req_cycles"}, req_n, e_req);
        chk({tag, " rdata"}, rd_o, e_rd);
        if (e_req > 0) begin
            chk({tag, " mem_be"}, {28'd0, be_o}, {28'd0, e_be});
            chk({tag, " mem_we"}, {31'd0, we_o}, {31'd0, ~rw_i});
            chk({tag, " mem_addr"}, {24'd0, addr_o}, {24'd0, a[7:0]});
            if (!rw_i) chk({tag, " mem_wdata"}, wd_o, e_wd);
        end
    endtask

    // Reference: byte count, lane shift and extension computed arithmetically.
    task automatic model(input logic rw_i, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] w, input logic [31:0] rm,
                         input int ack_at, output int req_n, output int done_c, output logic e,
                         output logic [3:0] be, output logic [31:0] wd);
        int n;
        logic [31:0] mask, v;
        if (sz == 3 || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0)) begin
            req_n = 0; done_c = 1; e = 1;
        end else if (ack_at >= 1 && ack_at <= 15) begin
            req_n = ack_at; done_c = ack_at + 1; e = 0;
        end else begin
            req_n = 15; done_c = 16; e = 1;
        end
        n = 1 << sz;
        be = 4'(((1 << n) - 1) << (a % 4));
        wd = sz == 0 ? (w & 32'hFF) * 32'h01010101 : sz == 1 ? (w & 32'hFFFF) * 32'h00010001 : w;
        if (!e && rw_i) begin
            mask = n == 4 ? 32'hFFFFFFFF : (32'h1 << (8 * n)) - 1;
            v = (rm >> (8 * (a % 4))) & mask;
            if (sg && n < 4 && v[8 * n - 1]) v = v | ~mask;
            mdr_model = v;
        end
    endtask

    initial begin
        tbl[0] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1, 1, 2, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b1, 2'd0, 1'b1, 32'h13, 32'h0,        32'h80FF1234, 1, 1, 2, 1'b0, 4'h8, 32'h0, 32'hFFFFFF80};
        tbl[2] = '{1'b1, 2'd0, 1'b0, 32'h13, 32'h0,        32'h80FF1234, 1, 1, 2, 1'b0, 4'h8, 32'h0, 32'h00000080};
        tbl[3] = '{1'b1, 2'd1, 1'b0, 32'h22, 32'h0,        32'h80017FFF, 3, 3, 4, 1'b0, 4'hC, 32'h0, 32'h00008001};
        tbl[4] = '{1'b0, 2'd0, 1'b0, 32'h21, 32'h000000A5, 32'h0,        1, 1, 2, 1'b0, 4'h2, 32'hA5A5A5A5, 32'h00008001};
        tbl[5] = '{1'b1, 2'd2, 1'b0, 32'h05, 32'h0,        32'h0,        1, 0, 1, 1'b1, 4'h0, 32'h0, 32'h00008001};
        tbl[6] = '{1'b1, 2'd1, 1'b1, 32'h20, 32'h0,        32'h12348001, 2, 2, 3, 1'b0, 4'h3, 32'h0, 32'hFFFF8001};
        tbl[7] = '{1'b0, 2'd3, 1'b0, 32'h20, 32'h11223344, 32'h0,        1, 0, 1, 1'b1, 4'h0, 32'h0, 32'hFFFF8001};
        tbl[8] = '{1'b0, 2'd1, 1'b0, 32'h2E, 32'h0000BEEF, 32'h0,        4, 4, 5, 1'b0, 4'hC, 32'hBEEFBEEF, 32'hFFFF8001};

        #12;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done_err", {30'd0, done, err}, 32'd0);
        chk("reset req_we", {30'd0, mem_req, mem_we}, 32'd0);
        chk("reset mem_be", {28'd0, mem_be}, 32'd0);
        chk("reset rdata", rdata, 32'd0);
        chk("reset mar_wdata", {24'd0, mem_addr} | mem_wdata, 32'd0);
        CLR = 1'b1;
        tick();

        for (int i = 0; i < 9; i++)
            run_check($sformatf("tbl%0d", i), tbl[i].rw, tbl[i].size, tbl[i].sign, tbl[i].addr,
                      tbl[i].wdata, tbl[i].rmem, tbl[i].ack, tbl[i].e_req, tbl[i].e_done,
                      tbl[i].e_err, tbl[i].e_be, tbl[i].e_wd, tbl[i].e_rd);

        begin : timeout_seq
            int req_n = 0, done_c = -1, n_done = 0;
            logic e = 1'b0, addr_ok = 1'b1;
            rw = 1'b1; size = 2'd2; sign = 1'b0; addr = 32'h40; start = 1'b1;
            tick();
            start = 1'b0;
            for (int c = 1; c <= 20; c++) begin
                if (mem_req) begin req_n++; if (mem_addr != 8'h40) addr_ok = 1'b0; end
                if (done) begin n_done++; done_c = c; e = err; end
                start = (c == 3 || c == 9);
                rw = 1'b0; addr = 32'h44;
                mem_ack = (c == 17);
                mem_rdata = $urandom;
                tick();
            end
            start = 1'b0; mem_ack = 1'b0;
            chk("timeout req_cycles", req_n, 15);
            chk("timeout done_cycle", done_c, 16);
            chk("timeout err", {31'd0, e}, 32'd1);
            chk("timeout done_count", n_done, 1);
            chk("timeout addr_kept", {31'd0, addr_ok}, 32'd1);
            chk("timeout idle_after", {31'd0, busy}, 32'd0);
            chk("timeout rdata", rdata, 32'hFFFF8001);
        end

        begin : reset_seq
            int n_done = 0;
            rw = 1'b1; size = 2'd2; addr = 32'h30; start = 1'b1;
            tick();
            start = 1'b0;
            tick();
            CLR = 1'b0;
            #1;
            chk("clr mem_req", {31'd0, mem_req}, 32'd0);
            chk("clr busy", {31'd0, busy}, 32'd0);
            chk("clr rdata", rdata, 32'd0);
            for (int c = 0; c < 3; c++) begin
                if (done) n_done++;
                tick();
            end
            chk("clr no_done", n_done, 0);
            CLR = 1'b1;
            tick();
            mdr_model = 32'd0;
            run_check("after_clr", 1'b1, 2'd2, 1'b0, 32'h30, 32'h0, 32'hCAFEF00D, 2,
                      2, 3, 1'b0, 4'hF, 32'h0, 32'hCAFEF00D);
            mdr_model = 32'hCAFEF00D;
        end

        for (int i = 0; i < 200; i++) begin
            logic r, s;
            logic [1:0] sz;
            logic [31:0] a, w, rm, wd;
            logic [3:0] be;
            logic e;
            int ack, req_n, done_c;
            r = 1'($urandom); s = 1'($urandom); sz = 2'($urandom);
            a = 32'($urandom_range(0, 255)); w = $urandom; rm = $urandom;
            ack = $urandom_range(1, 17);
            model(r, sz, s, a, w, rm, ack, req_n, done_c, e, be, wd);
            run_check($sformatf("rnd%0d", i), r, sz, s, a, w, rm, ack, req_n, done_c, e, be, wd, mdr_model);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
